// File: rtl/iqmap_pkg.sv
// iqmap_pkg: shared definitions for the multi-mode I/Q mapper.
//   mode_e   - modulation mode encodings (reserved code maps like BPSK)
//   state_e  - word-fetch FSM states
//   DEF_*    - default widths and constellation amplitudes
//   bps()    - bits per symbol for a given mode
package iqmap_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEF_WORD_W    = 128;
  localparam int DEF_OUT_W     = 11;
  localparam int DEF_AMP_BPSK  = 512;
  localparam int DEF_AMP_QPSK  = 362;
  localparam int DEF_AMP_QAM16 = 162;

  function automatic logic [2:0] bps(input mode_e m);
    case (m)
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/iqmap_if.sv
// iqmap_if: reader handshake plus symbol/bit output bus of the mapper.
//   valid_i, reader_data : upstream word source -> mapper
//   reader_en            : mapper -> upstream one-cycle word request
//   xr, xi, valid_o      : signed I/Q symbol and its strobe
//   raw, valid_raw       : serialised bit and its strobe
// The mapper connects to the slave modport; the environment uses master.
interface iqmap_if
  import iqmap_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int OUT_W  = DEF_OUT_W
);
  logic                     valid_i;
  logic                     reader_en;
  logic        [WORD_W-1:0] reader_data;
  logic signed [OUT_W-1:0]  xr;
  logic signed [OUT_W-1:0]  xi;
  logic                     valid_o;
  logic                     raw;
  logic                     valid_raw;

  modport master (
    output valid_i, reader_data,
    input  reader_en, xr, xi, valid_o, raw, valid_raw
  );

  modport slave (
    input  valid_i, reader_data,
    output reader_en, xr, xi, valid_o, raw, valid_raw
  );
endinterface

// File: rtl/iqmap_lut.sv
// iqmap_lut: combinational constellation lookup.
//   mode  in  - modulation mode
//   sym   in  - accumulated symbol bits, bit0 = first serialised bit
//   xr/xi out - signed I/Q levels
// All levels are elaboration-time constants, so the datapath is a pure mux.
module iqmap_lut
  import iqmap_pkg::*;
#(
  parameter int OUT_W     = DEF_OUT_W,
  parameter int AMP_BPSK  = DEF_AMP_BPSK,
  parameter int AMP_QPSK  = DEF_AMP_QPSK,
  parameter int AMP_QAM16 = DEF_AMP_QAM16
) (
  input  mode_e                   mode,
  input  logic [3:0]              sym,
  output logic signed [OUT_W-1:0] xr,
  output logic signed [OUT_W-1:0] xi
);
  localparam int MAX_POS = (2 ** (OUT_W - 1)) - 1;

  if (AMP_BPSK > MAX_POS || AMP_QPSK > MAX_POS || 3 * AMP_QAM16 > MAX_POS) begin : g_amp_chk
    $error("iqmap_lut: amplitude does not fit OUT_W");
  end

  localparam logic signed [OUT_W-1:0] BP_P  = OUT_W'(AMP_BPSK);
  localparam logic signed [OUT_W-1:0] BP_N  = OUT_W'(-AMP_BPSK);
  localparam logic signed [OUT_W-1:0] QP_P  = OUT_W'(AMP_QPSK);
  localparam logic signed [OUT_W-1:0] QP_N  = OUT_W'(-AMP_QPSK);
  localparam logic signed [OUT_W-1:0] Q1_P  = OUT_W'(AMP_QAM16);
  localparam logic signed [OUT_W-1:0] Q1_N  = OUT_W'(-AMP_QAM16);
  localparam logic signed [OUT_W-1:0] Q3_P  = OUT_W'(3 * AMP_QAM16);
  localparam logic signed [OUT_W-1:0] Q3_N  = OUT_W'(-3 * AMP_QAM16);

  // One 16QAM axis: pos selects sign, inner selects the 1x level over 3x.
  function automatic logic signed [OUT_W-1:0] qam_axis(input logic pos, input logic inner);
    case ({pos, inner})
      2'b11:   return Q1_P;
      2'b10:   return Q3_P;
      2'b01:   return Q1_N;
      default: return Q3_N;
    endcase
  endfunction

  always_comb begin
    xr = '0;
    xi = '0;
    case (mode)
      MODE_QPSK: begin
        xr = sym[0] ? QP_P : QP_N;
        xi = sym[1] ? QP_P : QP_N;
      end
      MODE_QAM16: begin
        xr = qam_axis(sym[0], sym[2]);
        xi = qam_axis(sym[1], sym[3]);
      end
      default: begin
        xr = sym[0] ? BP_P : BP_N;
        xi = '0;
      end
    endcase
  end
endmodule

// File: rtl/iqmap_multi.sv
// iqmap_multi: BPSK/QPSK/16QAM mapper fed by a word reader.
//   CLK   in - clock
//   RST   in - asynchronous active-low reset
//   ce    in - clock enable; low freezes all state and masks strobes
//   mode  in - modulation, sampled at each word load
//   bus      - iqmap_if.slave: valid_i/reader_data/reader_en handshake,
//              xr/xi/valid_o symbol output, raw/valid_raw bit output
// Words are serialised LSB-first. A shadow word is prefetched three bits
// before the end of the current word so the stream stays gapless.
// The upstream reader is assumed to hold reader_data while ce is low.
module iqmap_multi
  import iqmap_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int AMP_BPSK  = DEF_AMP_BPSK,
  parameter int AMP_QPSK  = DEF_AMP_QPSK,
  parameter int AMP_QAM16 = DEF_AMP_QAM16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ce,
  input  logic [1:0] mode,
  iqmap_if.slave     bus
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  if (WORD_W % 4 != 0 || WORD_W < 4) begin : g_word_w_chk
    $error("iqmap_multi: WORD_W must be a non-zero multiple of 4");
  end

  state_e                  state_q, state_d;
  logic       [WORD_W-1:0] shift_q, shadow_q;
  logic                    shadow_full_q, fetch_pend_q;
  logic       [CNT_W-1:0]  bits_left_q;
  mode_e                   mode_q;
  logic       [3:0]        sym_q;
  logic       [1:0]        sym_cnt_q;

  logic       [WORD_W-1:0] word_p0;
  logic       [CNT_W-1:0]  left_p0;
  mode_e                   mode_p0;
  logic       [1:0]        cnt_p0;
  logic       [3:0]        sym_p0;
  logic                    bit_p0, emit_p0, last_p0, req;
  logic signed [OUT_W-1:0] lut_xr, lut_xi;

  logic                    raw_p1, vld_raw_p1, vld_o_p1;
  logic signed [OUT_W-1:0] xr_p1, xi_p1;

  // Stage p0: pick the bit source (fresh reader word in LOAD, shift register
  // in RUN) and fold the bit into the symbol being built.
  always_comb begin
    state_d = state_q;
    word_p0 = shift_q;
    left_p0 = bits_left_q;
    mode_p0 = mode_q;
    cnt_p0  = sym_cnt_q;
    emit_p0 = 1'b0;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          req     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        word_p0 = bus.reader_data;
        left_p0 = CNT_W'(WORD_W);
        mode_p0 = mode_e'(mode);
        cnt_p0  = 2'd0;
        emit_p0 = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        emit_p0 = 1'b1;
        // Only one request in flight: shadow empty and nothing pending.
        if (bits_left_q == CNT_W'(3) && bus.valid_i && !shadow_full_q && !fetch_pend_q)
          req = 1'b1;
        if (bits_left_q == CNT_W'(1) && !shadow_full_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    bit_p0         = word_p0[0];
    sym_p0         = (cnt_p0 == 2'd0) ? 4'b0000 : sym_q;
    sym_p0[cnt_p0] = bit_p0;
    last_p0        = ({1'b0, cnt_p0} == (bps(mode_p0) - 3'd1));
  end

  iqmap_lut #(
    .OUT_W     (OUT_W),
    .AMP_BPSK  (AMP_BPSK),
    .AMP_QPSK  (AMP_QPSK),
    .AMP_QAM16 (AMP_QAM16)
  ) u_lut (
    .mode (mode_p0),
    .sym  (sym_p0),
    .xr   (lut_xr),
    .xi   (lut_xi)
  );

  // Stage p1: state update and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      fetch_pend_q  <= 1'b0;
      bits_left_q   <= '0;
      mode_q        <= MODE_BPSK;
      sym_q         <= '0;
      sym_cnt_q     <= '0;
      raw_p1        <= 1'b0;
      vld_raw_p1    <= 1'b0;
      vld_o_p1      <= 1'b0;
      xr_p1         <= '0;
      xi_p1         <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      vld_raw_p1 <= emit_p0;
      vld_o_p1   <= emit_p0 && last_p0;

      if (req && state_q == ST_RUN)
        fetch_pend_q <= 1'b1;
      if (fetch_pend_q) begin
        shadow_q      <= bus.reader_data;
        shadow_full_q <= 1'b1;
        fetch_pend_q  <= 1'b0;
      end

      if (emit_p0) begin
        raw_p1 <= bit_p0;
        sym_q  <= sym_p0;
        if (last_p0) begin
          xr_p1     <= lut_xr;
          xi_p1     <= lut_xi;
          sym_cnt_q <= 2'd0;
        end else begin
          sym_cnt_q <= cnt_p0 + 2'd1;
        end
        if (left_p0 == CNT_W'(1) && shadow_full_q) begin
          // Hand over to the prefetched word without a bubble.
          shift_q       <= shadow_q;
          bits_left_q   <= CNT_W'(WORD_W);
          mode_q        <= mode_e'(mode);
          shadow_full_q <= 1'b0;
          sym_cnt_q     <= 2'd0;
        end else begin
          shift_q     <= word_p0 >> 1;
          bits_left_q <= left_p0 - CNT_W'(1);
          mode_q      <= mode_p0;
        end
      end
    end
  end

  // Strobes are masked while frozen; the held registers re-present the
  // pending strobe once on the first enabled cycle.
  assign bus.reader_en = req & ce & RST;
  assign bus.valid_raw = vld_raw_p1 & ce;
  assign bus.valid_o   = vld_o_p1 & ce;
  assign bus.raw       = raw_p1;
  assign bus.xr        = xr_p1;
  assign bus.xi        = xi_p1;
endmodule

// File: tb/tb_iqmap_multi.sv
module tb_iqmap_multi;
  import iqmap_pkg::*;

  localparam int WORD_W = 8;
  localparam int OUT_W  = 11;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce    = 1'b0;
  logic [1:0] mode  = MODE_BPSK;

  iqmap_if #(.WORD_W(WORD_W), .OUT_W(OUT_W)) bus ();

  iqmap_multi #(.WORD_W(WORD_W), .OUT_W(OUT_W)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .ce   (ce),
    .mode (mode),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit feed  = 1'b0;

  logic [WORD_W-1:0] word_q[$];
  logic raw_log[$];
  int   raw_cyc[$];
  int   xr_log[$];
  int   xi_log[$];
  int   o_cyc[$];
  int   ren_cyc[$];

  // Upstream reader: data appears the cycle after a request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.reader_en)
      bus.reader_data <= (word_q.size() > 0) ? word_q.pop_front() : '0;
  end

  always @(negedge clk) begin
    if (bus.valid_raw) begin
      raw_log.push_back(bus.raw);
      raw_cyc.push_back(cyc);
    end
    if (bus.valid_o) begin
      xr_log.push_back(int'(bus.xr));
      xi_log.push_back(int'(bus.xi));
      o_cyc.push_back(cyc);
    end
    if (bus.reader_en) ren_cyc.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (feed) bus.valid_i = (word_q.size() != 0);
  endtask

  task automatic clear_logs();
    raw_log.delete(); raw_cyc.delete(); xr_log.delete();
    xi_log.delete(); o_cyc.delete(); ren_cyc.delete();
  endtask

  task automatic wait_raw(input int n, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (raw_log.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic start_words(input logic [1:0] m);
    clear_logs();
    mode = m;
    feed = 1'b1;
    bus.valid_i = 1'b1;
  endtask

  task automatic drain();
    repeat (8) step();
    feed = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; bus.valid_i = 1'b1;
    repeat (3) step();
    tests++; if (bus.reader_en !== 1'b0) begin fails++; $display("FAIL reset_reader_en: got %b want 0", bus.reader_en); end
    tests++; if (bus.valid_raw !== 1'b0) begin fails++; $display("FAIL reset_valid_raw: got %b want 0", bus.valid_raw); end
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid_o: got %b want 0", bus.valid_o); end
    tests++; if (bus.raw !== 1'b0) begin fails++; $display("FAIL reset_raw: got %b want 0", bus.raw); end
    tests++; if (bus.xr !== 11'sd0 || bus.xi !== 11'sd0) begin fails++; $display("FAIL reset_xrxi: got %0d/%0d want 0/0", bus.xr, bus.xi); end
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_bpsk();
    bit to; int pos, ones, nzxi;
    word_q.push_back(8'h55); word_q.push_back(8'hFF);
    start_words(MODE_BPSK);
    wait_raw(16, 80, to);
    drain();
    tests++; if (to) begin fails++; $display("FAIL bpsk_timeout: got %0d bits want 16", raw_log.size()); end
    tests++; if (xr_log.size() != 16) begin fails++; $display("FAIL bpsk_count: got %0d want 16", xr_log.size()); end
    pos = 0; ones = 0; nzxi = 0;
    foreach (xr_log[i]) begin
      if (xr_log[i] > 0) pos++;
      if (xi_log[i] != 0) nzxi++;
    end
    foreach (raw_log[i]) if (raw_log[i]) ones++;
    tests++; if (pos != 12) begin fails++; $display("FAIL bpsk_pos: got %0d want 12", pos); end
    tests++; if (nzxi != 0) begin fails++; $display("FAIL bpsk_xi: got %0d nonzero want 0", nzxi); end
    tests++; if (ones != 12) begin fails++; $display("FAIL bpsk_raw_ones: got %0d want 12", ones); end
    tests++; if (ren_cyc.size() != 2) begin fails++; $display("FAIL bpsk_reader_en: got %0d want 2", ren_cyc.size()); end
    tests++; if (o_cyc.size() < 16 || o_cyc[15] - o_cyc[0] != 15) begin fails++; $display("FAIL bpsk_gapless: got %0d strobes want 16 contiguous", o_cyc.size()); end
    tests++; if (xr_log.size() < 2 || xr_log[0] != 512 || xr_log[1] != -512) begin fails++; $display("FAIL bpsk_first: got %0d,%0d want 512,-512", xr_log.size() > 0 ? xr_log[0] : 0, xr_log.size() > 1 ? xr_log[1] : 0); end
    tests++; if (ren_cyc.size() < 1 || raw_cyc.size() < 1 || raw_cyc[0] - ren_cyc[0] != 2) begin fails++; $display("FAIL bpsk_raw_latency: got %0d want 2", (ren_cyc.size() > 0 && raw_cyc.size() > 0) ? raw_cyc[0] - ren_cyc[0] : -1); end
    tests++; if (ren_cyc.size() < 1 || o_cyc.size() < 1 || o_cyc[0] - ren_cyc[0] != 2) begin fails++; $display("FAIL bpsk_o_latency: got %0d want 2", (ren_cyc.size() > 0 && o_cyc.size() > 0) ? o_cyc[0] - ren_cyc[0] : -1); end
  endtask

  task automatic test_qpsk();
    bit to;
    int exp_xr[4] = '{362, -362, 362, -362};
    int exp_xi[4] = '{362, 362, -362, -362};
    word_q.push_back(8'h1B);
    start_words(MODE_QPSK);
    wait_raw(8, 40, to);
    drain();
    tests++; if (xr_log.size() != 4) begin fails++; $display("FAIL qpsk_count: got %0d want 4", xr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= xr_log.size() || xr_log[i] != exp_xr[i] || xi_log[i] != exp_xi[i]) begin
        fails++;
        $display("FAIL qpsk_sym%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 i < xr_log.size() ? xr_log[i] : 0, i < xi_log.size() ? xi_log[i] : 0, exp_xr[i], exp_xi[i]);
      end
    end
    tests++; if (ren_cyc.size() < 1 || o_cyc.size() < 1 || o_cyc[0] - ren_cyc[0] != 3) begin fails++; $display("FAIL qpsk_latency: got %0d want 3", (ren_cyc.size() > 0 && o_cyc.size() > 0) ? o_cyc[0] - ren_cyc[0] : -1); end
  endtask

  task automatic test_qam16();
    bit to;
    int exp_v[2] = '{-486, 162};
    word_q.push_back(8'hF0);
    start_words(MODE_QAM16);
    wait_raw(8, 40, to);
    drain();
    tests++; if (xr_log.size() != 2) begin fails++; $display("FAIL qam_count: got %0d want 2", xr_log.size()); end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (i >= xr_log.size() || xr_log[i] != exp_v[i] || xi_log[i] != exp_v[i]) begin
        fails++;
        $display("FAIL qam_sym%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 i < xr_log.size() ? xr_log[i] : 0, i < xi_log.size() ? xi_log[i] : 0, exp_v[i], exp_v[i]);
      end
    end
    tests++; if (ren_cyc.size() < 1 || o_cyc.size() < 1 || o_cyc[0] - ren_cyc[0] != 5) begin fails++; $display("FAIL qam_latency: got %0d want 5", (ren_cyc.size() > 0 && o_cyc.size() > 0) ? o_cyc[0] - ren_cyc[0] : -1); end
  endtask

  task automatic test_mode_switch();
    bit to; int ex, ey;
    word_q.push_back(8'hFF); word_q.push_back(8'hFF);
    start_words(MODE_BPSK);
    wait_raw(3, 40, to);
    mode = MODE_QPSK;
    wait_raw(16, 60, to);
    drain();
    tests++; if (xr_log.size() != 12) begin fails++; $display("FAIL mode_count: got %0d want 12", xr_log.size()); end
    for (int i = 0; i < 12; i++) begin
      ex = (i < 8) ? 512 : 362;
      ey = (i < 8) ? 0 : 362;
      tests++;
      if (i >= xr_log.size() || xr_log[i] != ex || xi_log[i] != ey) begin
        fails++;
        $display("FAIL mode_sym%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 i < xr_log.size() ? xr_log[i] : 0, i < xi_log.size() ? xi_log[i] : 0, ex, ey);
      end
    end
  endtask

  task automatic test_ce_freeze();
    bit to; logic [15:0] got;
    word_q.push_back(8'hA5); word_q.push_back(8'h3C);
    start_words(MODE_BPSK);
    wait_raw(3, 40, to);
    ce = 1'b0;
    // Bit 3 of 8'hA5 (0) was emitted on the last enabled edge.
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (bus.valid_raw !== 1'b0 || bus.valid_o !== 1'b0 || bus.reader_en !== 1'b0) begin fails++; $display("FAIL ce_strobes%0d: got %b%b%b want 000", i, bus.valid_raw, bus.valid_o, bus.reader_en); end
      tests++; if (bus.raw !== 1'b0 || bus.xr !== -11'sd512) begin fails++; $display("FAIL ce_hold%0d: got raw %b xr %0d want raw 0 xr -512", i, bus.raw, bus.xr); end
    end
    ce = 1'b1;
    wait_raw(16, 60, to);
    drain();
    got = '0;
    foreach (raw_log[i]) if (i < 16) got[i] = raw_log[i];
    tests++; if (raw_log.size() != 16) begin fails++; $display("FAIL ce_bit_count: got %0d want 16", raw_log.size()); end
    tests++; if (got !== 16'h3CA5) begin fails++; $display("FAIL ce_stream: got %h want 3ca5", got); end
  endtask

  task automatic test_reset_mid();
    bit to; int c0; logic [7:0] got;
    word_q.push_back(8'hFF); word_q.push_back(8'hFF);
    start_words(MODE_BPSK);
    wait_raw(4, 40, to);
    feed = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.raw !== 1'b0 || bus.valid_raw !== 1'b0 || bus.valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_bits: got %b%b%b want 000", bus.raw, bus.valid_raw, bus.valid_o); end
    tests++; if (bus.xr !== 11'sd0 || bus.xi !== 11'sd0 || bus.reader_en !== 1'b0) begin fails++; $display("FAIL rstmid_sym: got %0d/%0d en %b want 0/0 en 0", bus.xr, bus.xi, bus.reader_en); end
    bus.valid_i = 1'b0;
    word_q.delete();
    repeat (2) step();
    clear_logs();
    rst_n = 1'b1;
    repeat (3) step();
    tests++; if (raw_log.size() != 0 || ren_cyc.size() != 0) begin fails++; $display("FAIL rstmid_idle: got %0d bits %0d req want 0 0", raw_log.size(), ren_cyc.size()); end
    word_q.push_back(8'h81);
    c0 = cyc;
    feed = 1'b1;
    bus.valid_i = 1'b1;
    wait_raw(8, 40, to);
    drain();
    tests++; if (ren_cyc.size() < 1 || ren_cyc[0] != c0) begin fails++; $display("FAIL rstmid_first_req: got cycle %0d want %0d", ren_cyc.size() > 0 ? ren_cyc[0] : -1, c0); end
    got = '0;
    foreach (raw_log[i]) if (i < 8) got[i] = raw_log[i];
    tests++; if (raw_log.size() != 8 || got !== 8'h81) begin fails++; $display("FAIL rstmid_stream: got %0d bits %h want 8 bits 81", raw_log.size(), got); end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_qam16();
    test_mode_switch();
    test_ce_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
